// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: tag/data widths, the "no producer" tag and
// the CDB broadcast bundle consumed by reservation stations.
// Latency: n/a (types and constants only). Backpressure: n/a.
package tomasulo_pkg;

  localparam int LABEL_W = 4;
  localparam int DATA_W  = 32;

  // Tag 0 marks an operand as already available; it never names a producer.
  localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

  typedef struct packed {
    logic               en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request side and CDB broadcast side of the CDB arbiter.
// Ports: req_valid/req_label/req_data in, req_ready out (per requester);
//        BCEN/BClabel/BCdata/grant_idx/err_label0 out (registered).
// slave = arbiter view, master = functional-unit / consumer view.
interface cdb_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int LABEL_W = tomasulo_pkg::LABEL_W,
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int IDX_W   = $clog2(N_REQ)
);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*LABEL_W-1:0] req_label;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     BCEN;
  logic [LABEL_W-1:0]       BClabel;
  logic [DATA_W-1:0]        BCdata;
  logic [IDX_W-1:0]         grant_idx;
  logic                     err_label0;

  modport slave (
    input  req_valid, req_label, req_data,
    output req_ready, BCEN, BClabel, BCdata, grant_idx, err_label0
  );

  modport master (
    output req_valid, req_label, req_data,
    input  req_ready, BCEN, BClabel, BCdata, grant_idx, err_label0
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req searching ptr, ptr+1, ... mod N.
// Ports: req[N], ptr[IDX_W] in; onehot[N], idx[IDX_W], any out.
// Latency: purely combinational. Backpressure: none (ptr must be < N).
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                          = 1'b1;
        idx                          = IDX_W'((int'(ptr) + k) % N);
        onehot[(int'(ptr) + k) % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Owns the Common Data Bus: one holding slot per functional unit, round-robin
// grant of one slot per cycle to the registered BCEN/BClabel/BCdata broadcast.
// Ports: clk, nRST (sync, active-low), bus (cdb_arbiter_if.slave).
// Latency: accept at edge k -> broadcast after edge k+1 (2 cycles req->BCEN).
// Backpressure: req_ready[i] low while slot i is full and not granted this cycle.
module cdb_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LABEL_W = tomasulo_pkg::LABEL_W,
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic         clk,
  input  logic         nRST,
  cdb_arbiter_if.slave bus
);
  import tomasulo_pkg::*;

  logic [N_REQ-1:0]   r_slot_vld;
  logic [LABEL_W-1:0] r_slot_label [N_REQ];
  logic [DATA_W-1:0]  r_slot_data  [N_REQ];
  logic [IDX_W-1:0]   r_ptr;

  logic               r_bcen;
  logic [LABEL_W-1:0] r_bclabel;
  logic [DATA_W-1:0]  r_bcdata;
  logic [IDX_W-1:0]   r_grant;
  logic               r_err;

  logic [N_REQ-1:0]   w_win;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [N_REQ-1:0]   w_rdy;
  logic [N_REQ-1:0]   w_acc;
  logic [N_REQ-1:0]   w_tag0;
  logic [LABEL_W-1:0] w_label [N_REQ];
  logic [DATA_W-1:0]  w_data  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_label[g] = bus.req_label[g*LABEL_W +: LABEL_W];
    assign w_data[g]  = bus.req_data[g*DATA_W +: DATA_W];
    assign w_tag0[g]  = (w_label[g] == LABEL_W'(LABEL_NONE));
  end

  // Arbitration looks only at held slots, so a fresh request can never reach
  // the bus in the cycle it arrives.
  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (r_slot_vld),
    .ptr    (r_ptr),
    .onehot (w_win),
    .idx    (w_idx),
    .any    (w_any)
  );

  // A slot being drained this cycle can take a new result at the same edge,
  // giving each requester back-to-back acceptance.
  assign w_rdy     = {N_REQ{nRST}} & (~r_slot_vld | w_win);
  assign w_acc     = bus.req_valid & w_rdy;
  assign w_ptr_nxt = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_slot_vld <= '0;
      r_ptr      <= '0;
      r_bcen     <= 1'b0;
      r_bclabel  <= '0;
      r_bcdata   <= '0;
      r_grant    <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        // Reload beats the clear of a granted slot; a tag-0 result is
        // swallowed, so a granted slot still empties.
        if (w_acc[i] && !w_tag0[i]) begin
          r_slot_vld[i]   <= 1'b1;
          r_slot_label[i] <= w_label[i];
          r_slot_data[i]  <= w_data[i];
        end else if (w_win[i]) begin
          r_slot_vld[i]   <= 1'b0;
        end
      end

      r_err <= |(w_acc & w_tag0);

      if (w_any) begin
        r_bcen    <= 1'b1;
        r_bclabel <= r_slot_label[w_idx];
        r_bcdata  <= r_slot_data[w_idx];
        r_grant   <= w_idx;
        r_ptr     <= w_ptr_nxt;
      end else begin
        r_bcen    <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_rdy;
  assign bus.BCEN       = r_bcen;
  assign bus.BClabel    = r_bclabel;
  assign bus.BCdata     = r_bcdata;
  assign bus.grant_idx  = r_grant;
  assign bus.err_label0 = r_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver steps a slot-level reference model
// and queues expected broadcasts; a negedge monitor pops and compares them.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  cdb_arbiter_if #(.N_REQ(N), .LABEL_W(LW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.N_REQ(N), .LABEL_W(LW), .DATA_W(DW)) dut (
    .clk  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    int            cyc;
    logic [LW-1:0] lab;
    logic [DW-1:0] dat;
    int            idx;
  } bc_t;

  bc_t           exp_q[$];
  logic [LW-1:0] bc_log[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model: what each holding slot contains, and whose turn it is.
  bit            m_full [N];
  logic [LW-1:0] m_lab  [N];
  logic [DW-1:0] m_dat  [N];
  int            m_ptr = 0;
  logic          m_err = 1'b0;

  // Requester-side stimulus state.
  logic [N-1:0]  v = '0;
  logic [LW-1:0] lab [N];
  logic [DW-1:0] dat [N];
  logic [N-1:0]  last_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  bit  mon_ev;
  bc_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      checks++;
      if (bus.BCEN !== mon_ev) begin
        errors++;
        $display("FAIL bcen cyc=%0d got=%b want=%b", cyc, bus.BCEN, mon_ev);
      end
      if (mon_ev) begin
        mon_e = exp_q.pop_front();
        if (bus.BCEN === 1'b1) begin
          checks++;
          if (bus.BClabel !== mon_e.lab || bus.BCdata !== mon_e.dat ||
              int'(bus.grant_idx) != mon_e.idx) begin
            errors++;
            $display("FAIL bc_payload cyc=%0d got lab=%0d dat=%h idx=%0d want lab=%0d dat=%h idx=%0d",
                     cyc, bus.BClabel, bus.BCdata, bus.grant_idx,
                     mon_e.lab, mon_e.dat, mon_e.idx);
          end
        end
      end
      if (bus.BCEN === 1'b1) bc_log.push_back(bus.BClabel);
      checks++;
      if (bus.err_label0 !== m_err) begin
        errors++;
        $display("FAIL err_label0 cyc=%0d got=%b want=%b", cyc, bus.err_label0, m_err);
      end
    end
  end

  // One clock of stimulus plus the matching model update.
  task automatic step();
    logic [N*LW-1:0] pl;
    logic [N*DW-1:0] pd;
    logic [N-1:0]    er;
    logic [N-1:0]    acc;
    int              w;
    int              c;
    logic            e;
    bc_t             b;
    for (int i = 0; i < N; i++) begin
      pl[i*LW +: LW] = lab[i];
      pd[i*DW +: DW] = dat[i];
    end
    bus.req_valid = v;
    bus.req_label = pl;
    bus.req_data  = pd;
    @(negedge clk);
    c = cyc;
    w = -1;
    if (rst_n)
      for (int k = 0; k < N; k++)
        if (w < 0 && m_full[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    er = '0;
    if (rst_n)
      for (int i = 0; i < N; i++) er[i] = !m_full[i] || (i == w);
    checks++;
    if (bus.req_ready !== er) begin
      errors++;
      $display("FAIL req_ready cyc=%0d got=%b want=%b", c, bus.req_ready, er);
    end
    acc = v & er;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      if (w >= 0) begin
        b.cyc = c + 1;
        b.lab = m_lab[w];
        b.dat = m_dat[w];
        b.idx = w;
        exp_q.push_back(b);
        m_full[w] = 1'b0;
        m_ptr     = (w + 1) % N;
      end
      e = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if (lab[i] == '0) e = 1'b1;
          else begin
            m_full[i] = 1'b1;
            m_lab[i]  = lab[i];
            m_dat[i]  = dat[i];
          end
        end
      end
      m_err = e;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle(input int n);
    v = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int log_start;

  initial begin
    for (int i = 0; i < N; i++) begin
      lab[i] = '0;
      dat[i] = '0;
    end

    // Reset then idle
    rst_n = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    checks++;
    if (bus.BCEN !== 1'b0 || bus.BClabel !== '0 || bus.BCdata !== '0 ||
        bus.grant_idx !== '0 || bus.err_label0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got bcen=%b lab=%h dat=%h idx=%h err=%b want all zero",
               bus.BCEN, bus.BClabel, bus.BCdata, bus.grant_idx, bus.err_label0);
    end
    rst_n = 1'b1;
    idle(3);

    // Single result from requester 2
    v[2] = 1'b1; lab[2] = 4'd5; dat[2] = 32'hDEADBEEF;
    step();
    idle(4);

    // Simultaneous four from ptr = 0
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      lab[i] = LW'(i + 1);
      dat[i] = $urandom;
    end
    v = '1;
    step();
    idle(6);

    // Fairness: requesters 0 and 3 always valid
    log_start = bc_log.size();
    lab[0] = 4'd7; lab[3] = 4'd9;
    dat[0] = $urandom; dat[3] = $urandom;
    v = 4'b1001;
    for (int k = 0; k < 16; k++) begin
      step();
      if (last_acc[0]) dat[0] = $urandom;
      if (last_acc[3]) dat[3] = $urandom;
    end
    idle(4);
    checks++;
    if (bc_log.size() - log_start < 10) begin
      errors++;
      $display("FAIL fair_count got=%0d want>=10", bc_log.size() - log_start);
    end
    for (int j = log_start + 1; j < bc_log.size(); j++) begin
      checks++;
      if (bc_log[j] == bc_log[j-1]) begin
        errors++;
        $display("FAIL fair_alternate pos=%0d got=%0d twice want alternating", j, bc_log[j]);
      end
    end

    // Back-pressure with reload in the grant cycle
    v = 4'b0011;
    lab[0] = 4'd3; lab[1] = 4'd6;
    dat[0] = $urandom; dat[1] = $urandom;
    for (int k = 0; k < 12; k++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (last_acc[i]) begin
          lab[i] = LW'($urandom_range(1, 15));
          dat[i] = $urandom;
        end
    end
    idle(4);

    // Tag 0: single, then two in the same cycle
    v = 4'b0010; lab[1] = '0; dat[1] = 32'h1234_5678;
    step();
    idle(3);
    v = 4'b0101; lab[0] = '0; lab[2] = '0;
    step();
    idle(3);

    // Mid-run reset with three slots full
    v = 4'b0111; lab[0] = 4'hA; lab[1] = 4'hB; lab[2] = 4'hC;
    step();
    v = '0;
    pulse_reset();
    idle(6);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]   = 1'b1;
          lab[i] = LW'($urandom_range(0, 15));
          dat[i] = $urandom;
        end
      rst_n = ($urandom_range(0, 127) != 0);
      step();
      for (int i = 0; i < N; i++)
        if (last_acc[i]) v[i] = 1'b0;
    end
    rst_n = 1'b1;
    idle(8);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
